// File: rtl/queue_pkg.sv
// Shared types, defaults and ticket arithmetic for the counter dispatcher.
package queue_pkg;

  localparam int TICKET_W        = 8;
  localparam int DEF_NUM_DESKS   = 4;
  localparam int DEF_QUEUE_DEPTH = 32;
  localparam int DEF_CALL_HOLD   = 3;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_ANNOUNCE = 1'b1
  } disp_state_e;

  // Tickets run 1..255; 0 is reserved to mean "no ticket".
  function automatic logic [TICKET_W-1:0] ticket_next(input logic [TICKET_W-1:0] t);
    return (t == '1) ? TICKET_W'(1) : t + TICKET_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  logic [PW-1:0] idx;

  // First requester at or after the pointer wins.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_dispatcher.sv
// Ticket dispenser and desk caller.
//   state       | meaning
//   ST_IDLE     | free to grant the head ticket to an open, idle desk
//   ST_ANNOUNCE | holding the call announcement for CALL_HOLD cycles
module counter_dispatcher import queue_pkg::*; #(
  parameter int NUM_DESKS   = DEF_NUM_DESKS,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
  parameter int CALL_HOLD   = DEF_CALL_HOLD,
  localparam int DW = (NUM_DESKS > 1) ? $clog2(NUM_DESKS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            btn_new,
  input  logic [NUM_DESKS-1:0]            btn_done,
  input  logic [NUM_DESKS-1:0]            desk_open,
  output logic [TICKET_W-1:0]             next_ticket,
  output logic [7:0]                      waiting,
  output logic                            full,
  output logic [NUM_DESKS-1:0]            desk_busy,
  output logic [NUM_DESKS*TICKET_W-1:0]   desk_ticket,
  output logic                            call_valid,
  output logic [DW-1:0]                   call_desk,
  output logic [TICKET_W-1:0]             call_ticket
);

  disp_state_e                   state_q;
  logic                          new_prev_q;
  logic [NUM_DESKS-1:0]          done_prev_q;
  logic [TICKET_W-1:0]           next_ticket_q, head_q;
  logic [7:0]                    waiting_q, waiting_d;
  logic [NUM_DESKS-1:0]          desk_busy_q, desk_busy_d;
  logic [NUM_DESKS*TICKET_W-1:0] desk_ticket_q, desk_ticket_d;
  logic                          call_valid_q;
  logic [DW-1:0]                 call_desk_q, rr_ptr_q, gnt_idx;
  logic [TICKET_W-1:0]           call_ticket_q;
  logic [7:0]                    hold_q;

  logic                          new_ev, new_acc, grant, arb_valid, full_w;
  logic [NUM_DESKS-1:0]          done_ev, arb_gnt;

  rr_arbiter #(.N(NUM_DESKS), .PW(DW)) u_arb (
    .req_i   (desk_open & ~desk_busy_q),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  assign full_w  = (waiting_q == 8'(QUEUE_DEPTH));
  assign new_ev  = btn_new & ~new_prev_q;
  assign done_ev = btn_done & ~done_prev_q;
  assign new_acc = new_ev & ~full_w;
  assign grant   = (state_q == ST_IDLE) && (waiting_q != 8'd0) && arb_valid;

  // Encode the one-hot grant to a desk index.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_DESKS; i++) begin
      if (arb_gnt[i]) gnt_idx = DW'(i);
    end
  end

  // Next queue count and desk occupancy; done only clears, grant only sets idle desks.
  always_comb begin
    waiting_d = waiting_q;
    if (new_acc && !grant)      waiting_d = waiting_q + 8'd1;
    else if (!new_acc && grant) waiting_d = waiting_q - 8'd1;
    desk_busy_d   = (desk_busy_q & ~done_ev) | (grant ? arb_gnt : '0);
    desk_ticket_d = desk_ticket_q;
    for (int i = 0; i < NUM_DESKS; i++) begin
      if (grant && arb_gnt[i]) desk_ticket_d[TICKET_W*i +: TICKET_W] = head_q;
    end
  end

  // All state, including the call FSM and its registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      new_prev_q    <= 1'b1;
      done_prev_q   <= '1;
      next_ticket_q <= TICKET_W'(1);
      head_q        <= TICKET_W'(1);
      waiting_q     <= '0;
      desk_busy_q   <= '0;
      desk_ticket_q <= '0;
      call_valid_q  <= 1'b0;
      call_desk_q   <= '0;
      call_ticket_q <= '0;
      rr_ptr_q      <= '0;
      hold_q        <= '0;
    end else begin
      new_prev_q  <= btn_new;
      done_prev_q <= btn_done;
      if (new_acc) next_ticket_q <= ticket_next(next_ticket_q);
      waiting_q     <= waiting_d;
      desk_busy_q   <= desk_busy_d;
      desk_ticket_q <= desk_ticket_d;
      case (state_q)
        ST_IDLE: begin
          if (grant) begin
            state_q       <= ST_ANNOUNCE;
            call_valid_q  <= 1'b1;
            call_desk_q   <= gnt_idx;
            call_ticket_q <= head_q;
            hold_q        <= 8'(CALL_HOLD - 1);
            head_q        <= ticket_next(head_q);
            rr_ptr_q      <= (gnt_idx == DW'(NUM_DESKS - 1)) ? '0 : gnt_idx + DW'(1);
          end
        end
        ST_ANNOUNCE: begin
          if (hold_q == 8'd0) begin
            state_q      <= ST_IDLE;
            call_valid_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign next_ticket = next_ticket_q;
  assign waiting     = waiting_q;
  assign full        = full_w;
  assign desk_busy   = desk_busy_q;
  assign desk_ticket = desk_ticket_q;
  assign call_valid  = call_valid_q;
  assign call_desk   = call_desk_q;
  assign call_ticket = call_ticket_q;

endmodule

// File: tb/tb_counter_dispatcher.sv
// Directed bench for counter_dispatcher; inputs change and outputs are sampled on the falling edge.
module tb_counter_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_new;
  logic [3:0]  btn_done;
  logic [3:0]  desk_open;
  logic [7:0]  next_ticket, waiting, call_ticket;
  logic        full, call_valid;
  logic [3:0]  desk_busy;
  logic [31:0] desk_ticket;
  logic [1:0]  call_desk;

  int n_chk = 0;
  int n_pass = 0;

  int mon_n = 0;
  int zero_seen = 0;
  int mon_tkt [0:299];
  int mon_desk[0:299];
  int mon_len [0:299];
  int cur_len = 0;
  logic prev_cv = 1'b0;

  always #5 clk = ~clk;

  counter_dispatcher dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_new     (btn_new),
    .btn_done    (btn_done),
    .desk_open   (desk_open),
    .next_ticket (next_ticket),
    .waiting     (waiting),
    .full        (full),
    .desk_busy   (desk_busy),
    .desk_ticket (desk_ticket),
    .call_valid  (call_valid),
    .call_desk   (call_desk),
    .call_ticket (call_ticket)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic press_new();
    btn_new = 1'b1;
    step(1);
    btn_new = 1'b0;
    step(1);
  endtask

  task automatic pulse_done(input int d);
    btn_done[d] = 1'b1;
    step(1);
    btn_done[d] = 1'b0;
    step(1);
  endtask

  // Records every announcement: desk, ticket and how many cycles call_valid stayed high.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cv <= 1'b0;
      cur_len <= 0;
    end else begin
      if (call_valid && call_ticket == 8'd0) zero_seen <= zero_seen + 1;
      if (call_valid && !prev_cv) begin
        mon_tkt[mon_n]  <= int'(call_ticket);
        mon_desk[mon_n] <= int'(call_desk);
        cur_len <= 1;
      end else if (call_valid) begin
        cur_len <= cur_len + 1;
      end else if (prev_cv) begin
        mon_len[mon_n] <= cur_len;
        mon_n <= mon_n + 1;
      end
      prev_cv <= call_valid;
    end
  end

  initial begin
    int tmo;
    int exp_t;
    rst_n = 1'b0; btn_new = 1'b0; btn_done = '0; desk_open = '0;

    // Reset values.
    step(2);
    chk("rst_next", next_ticket, 1);
    chk("rst_wait", waiting, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", desk_busy, 0);
    chk("rst_dtkt", desk_ticket, 0);
    chk("rst_cv", call_valid, 0);
    rst_n = 1'b1;
    step(1);

    // Three clients, all desks open: tickets 1,2,3 to desks 0,1,2.
    desk_open = 4'hF;
    mon_n = 0;
    repeat (3) press_new();
    for (int i = 0; i < 100 && !(mon_n == 3 && waiting == 0 && !call_valid); i++) step(1);
    step(2);
    chk("seq_calls", mon_n, 3);
    for (int i = 0; i < 3; i++) begin
      chk("seq_ticket", mon_tkt[i], i + 1);
      chk("seq_desk", mon_desk[i], i);
      chk("seq_len", mon_len[i], 3);
    end
    chk("seq_wait", waiting, 0);

    // Queue fills at 32; the 33rd client is turned away.
    do_reset();
    desk_open = 4'h0;
    repeat (32) press_new();
    chk("fill_wait", waiting, 32);
    chk("fill_full", full, 1);
    chk("fill_next", next_ticket, 33);
    press_new();
    chk("over_wait", waiting, 32);
    chk("over_full", full, 1);
    chk("over_next", next_ticket, 33);

    // 256 tickets through one desk: 255 wraps to 1, never 0.
    do_reset();
    desk_open = 4'h1;
    zero_seen = 0;
    tmo = 0;
    for (int k = 0; k < 256; k++) begin
      exp_t = (k % 255) + 1;
      press_new();
      for (int i = 0; i < 20 && !call_valid; i++) step(1);
      if (!call_valid) tmo++;
      chk("wrap_ticket", call_ticket, exp_t);
      pulse_done(0);
      for (int i = 0; i < 20 && call_valid; i++) step(1);
      if (call_valid) tmo++;
    end
    chk("wrap_timeouts", tmo, 0);
    chk("wrap_zero", zero_seen, 0);

    // All desks busy with two waiting; freeing desk 2 hands it ticket 5.
    do_reset();
    desk_open = 4'hF;
    repeat (6) press_new();
    for (int i = 0; i < 100 && !(desk_busy == 4'hF && !call_valid && waiting == 2); i++) step(1);
    chk("busy4_busy", desk_busy, 4'hF);
    chk("busy4_wait", waiting, 2);
    btn_done[2] = 1'b1;
    step(1);
    chk("free2_busy", desk_busy, 4'b1011);
    btn_done[2] = 1'b0;
    step(1);
    chk("regrant_busy", desk_busy, 4'hF);
    chk("regrant_dtkt2", desk_ticket[23:16], 5);
    chk("regrant_cdesk", call_desk, 2);
    chk("regrant_ctkt", call_ticket, 5);
    chk("regrant_cv", call_valid, 1);
    chk("regrant_wait", waiting, 1);
    desk_open = 4'h0;
    step(4);
    chk("closed_busy", desk_busy, 4'hF);
    pulse_done(0);
    chk("done0_busy", desk_busy, 4'b1110);
    chk("done0_dtkt", desk_ticket, 32'h04050201);
    chk("done0_wait", waiting, 1);
    pulse_done(0);
    chk("idle_done_busy", desk_busy, 4'b1110);
    chk("idle_done_dtkt", desk_ticket, 32'h04050201);
    chk("idle_done_wait", waiting, 1);
    chk("idle_done_cv", call_valid, 0);

    // Held button gives one ticket; new event coinciding with a grant nets zero.
    do_reset();
    desk_open = 4'h0;
    btn_new = 1'b1;
    step(10);
    btn_new = 1'b0;
    step(2);
    chk("hold_wait", waiting, 1);
    chk("hold_next", next_ticket, 2);
    desk_open = 4'h1;
    btn_new = 1'b1;
    step(1);
    chk("both_wait", waiting, 1);
    chk("both_next", next_ticket, 3);
    chk("both_cv", call_valid, 1);
    chk("both_ctkt", call_ticket, 1);

    // Reset during the announcement, button still held through release.
    rst_n = 1'b0;
    step(1);
    chk("abort_next", next_ticket, 1);
    chk("abort_wait", waiting, 0);
    chk("abort_full", full, 0);
    chk("abort_busy", desk_busy, 0);
    chk("abort_dtkt", desk_ticket, 0);
    chk("abort_cv", call_valid, 0);
    chk("abort_cdesk", call_desk, 0);
    chk("abort_ctkt", call_ticket, 0);
    rst_n = 1'b1;
    step(5);
    chk("held_rel_wait", waiting, 0);
    chk("held_rel_next", next_ticket, 1);
    chk("held_rel_cv", call_valid, 0);
    btn_new = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
